// File: rtl/tuple_wr_queue.sv
// In-order write-request queue feeding the tuple array write port.
// Define TUPLE_WR_QUEUE_COALESCE_EN to merge writes to a queued address.
module tuple_wr_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 3,
  parameter int DW    = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AW-1:0]          in_addr,
  input  logic [DW-1:0]          in_data,
  input  logic                   flush,
  input  logic                   out_en,
  output logic                   we0,
  output logic [AW-1:0]          waddr0,
  output logic [DW-1:0]          din0,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          pop;
  logic          accept;
  logic          push;

  assign empty  = (count == '0);
  assign full   = (count == (PW+1)'(DEPTH));
  assign pop    = ~empty & out_en & ~flush;
  assign accept = in_valid & in_ready;

`ifdef TUPLE_WR_QUEUE_COALESCE_EN
  logic          match;
  logic [PW-1:0] match_idx;
  logic [PW-1:0] off;
  logic [PW-1:0] idx;

  // Scan live entries by age; the head leaving this cycle cannot match.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    off       = '0;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i);
      idx = rd_ptr + off;
      if (({1'b0, off} < count) &&
          !(pop && (off == '0)) &&
          (addr_q[idx] == in_addr)) begin
        match     = 1'b1;
        match_idx = idx;
      end
    end
  end

  assign in_ready = (~full | match) & ~flush;
  assign push     = accept & ~match;
`else
  assign in_ready = ~full & ~flush;
  assign push     = accept;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      we0    <= 1'b0;
      waddr0 <= '0;
      din0   <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      we0    <= 1'b0;
    end else begin
      we0 <= pop;
      if (pop) begin
        waddr0 <= addr_q[rd_ptr];
        din0   <= data_q[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= in_addr;
      data_q[wr_ptr] <= in_data;
    end
`ifdef TUPLE_WR_QUEUE_COALESCE_EN
    else if (accept) begin
      data_q[match_idx] <= in_data;
    end
`endif
  end

endmodule

// File: tb/tb_tuple_wr_queue.sv
// Self-checking bench for tuple_wr_queue: vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_tuple_wr_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_addr;
  logic [3:0] in_data;
  logic       flush;
  logic       out_en;
  logic       we0;
  logic [2:0] waddr0;
  logic [3:0] din0;
  logic [2:0] count;
  logic       empty;
  logic       full;

  int checks = 0;
  int errors = 0;

  logic [2:0] mq_a [$];
  logic [3:0] mq_d [$];
  logic       exp_we;
  logic [2:0] exp_a;
  logic [3:0] exp_d;

  typedef struct {
    logic       v;
    logic [2:0] a;
    logic [3:0] d;
    logic       oe;
    logic       fl;
    logic       e_we;
    logic [2:0] e_a;
    logic [3:0] e_d;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t vecs [7];

  tuple_wr_queue #(.DEPTH(DEPTH), .AW(3), .DW(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .flush    (flush),
    .out_en   (out_en),
    .we0      (we0),
    .waddr0   (waddr0),
    .din0     (din0),
    .count    (count),
    .empty    (empty),
    .full     (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    in_valid = 1'b1;
    in_addr  = 3'd6;
    in_data  = 4'hC;
    flush    = 1'b0;
    out_en   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 8'(count), 8'd0);
    chk("rst_we0", 8'(we0), 8'd0);
    chk("rst_waddr0", 8'(waddr0), 8'd0);
    chk("rst_din0", 8'(din0), 8'd0);
    mq_a.delete();
    mq_d.delete();
    exp_we = 1'b0;
    exp_a  = '0;
    exp_d  = '0;
    @(negedge clk);
    reset_n  = 1'b1;
    in_valid = 1'b0;
    out_en   = 1'b0;
    #1;
    chk("rel_in_ready", 8'(in_ready), 8'd1);
    chk("rel_empty", 8'(empty), 8'd1);
  endtask

  // One clock of stimulus; the model predicts from queue contents alone.
  task automatic tick(input logic v, input logic [2:0] a,
                      input logic [3:0] d, input logic oe,
                      input logic fl);
    int  msz;
    int  mk;
    bit  mpop;
    bit  mrdy;
    @(negedge clk);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    out_en   = oe;
    flush    = fl;
    #1;
    msz  = mq_a.size();
    mpop = (msz > 0) && oe && !fl;
    mk   = -1;
`ifdef TUPLE_WR_QUEUE_COALESCE_EN
    for (int k = (mpop ? 1 : 0); k < msz; k++)
      if (mq_a[k] == a) mk = k;
`endif
    mrdy = !fl && ((msz < DEPTH) || (mk >= 0));
    chk("in_ready", 8'(in_ready), 8'(mrdy));
    chk("count_pre", 8'(count), 8'(msz));
    chk("empty", 8'(empty), 8'(msz == 0));
    chk("full", 8'(full), 8'(msz == DEPTH));
    @(posedge clk);
    #1;
    if (fl) begin
      mq_a.delete();
      mq_d.delete();
      exp_we = 1'b0;
    end else begin
      if (v && mrdy && mk >= 0) mq_d[mk] = d;
      if (mpop) begin
        exp_we = 1'b1;
        exp_a  = mq_a.pop_front();
        exp_d  = mq_d.pop_front();
      end else begin
        exp_we = 1'b0;
      end
      if (v && mrdy && mk < 0) begin
        mq_a.push_back(a);
        mq_d.push_back(d);
      end
    end
    chk("we0", 8'(we0), 8'(exp_we));
    chk("waddr0", 8'(waddr0), 8'(exp_a));
    chk("din0", 8'(din0), 8'(exp_d));
    chk("count_post", 8'(count), 8'(mq_a.size()));
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    flush    = 1'b0;
    out_en   = 1'b0;

    // Ordered drain as a fixed vector table.
    vecs[0] = '{1, 3'd1, 4'hA, 0, 0, 0, 3'd0, 4'h0, 3'd1};
    vecs[1] = '{1, 3'd5, 4'h3, 0, 0, 0, 3'd0, 4'h0, 3'd2};
    vecs[2] = '{1, 3'd7, 4'hF, 0, 0, 0, 3'd0, 4'h0, 3'd3};
    vecs[3] = '{0, 3'd0, 4'h0, 1, 0, 1, 3'd1, 4'hA, 3'd2};
    vecs[4] = '{0, 3'd0, 4'h0, 1, 0, 1, 3'd5, 4'h3, 3'd1};
    vecs[5] = '{0, 3'd0, 4'h0, 1, 0, 1, 3'd7, 4'hF, 3'd0};
    vecs[6] = '{0, 3'd0, 4'h0, 1, 0, 0, 3'd7, 4'hF, 3'd0};

    do_reset();
    for (int i = 0; i < 7; i++) begin
      tick(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].oe, vecs[i].fl);
      chk("tbl_we0", 8'(we0), 8'(vecs[i].e_we));
      chk("tbl_waddr0", 8'(waddr0), 8'(vecs[i].e_a));
      chk("tbl_din0", 8'(din0), 8'(vecs[i].e_d));
      chk("tbl_count", 8'(count), 8'(vecs[i].e_cnt));
    end
    chk("tbl_empty", 8'(empty), 8'd1);

    // Full boundary: 5th refused, pop at full still refuses, then accepted.
    do_reset();
    for (int i = 0; i < 4; i++) tick(1, 3'(i), 4'(i + 8), 0, 0);
    chk("full_set", 8'(full), 8'd1);
    tick(1, 3'd4, 4'hC, 0, 0);
    chk("full_refused", 8'(count), 8'd4);
    tick(1, 3'd4, 4'hC, 1, 0);
    tick(1, 3'd4, 4'hC, 0, 0);
    chk("full_refill", 8'(count), 8'd4);
    for (int i = 0; i < 5; i++) tick(0, 3'd0, 4'h0, 1, 0);
    chk("full_last_a", 8'(waddr0), 8'd4);
    chk("full_last_d", 8'(din0), 8'hC);

    // Flush after the first issued write.
    do_reset();
    for (int i = 0; i < 3; i++) tick(1, 3'(i + 2), 4'(i + 1), 0, 0);
    tick(0, 3'd0, 4'h0, 1, 0);
    chk("fl_first_we", 8'(we0), 8'd1);
    tick(1, 3'd6, 4'h6, 1, 1);
    chk("fl_we0", 8'(we0), 8'd0);
    chk("fl_count", 8'(count), 8'd0);
    tick(0, 3'd0, 4'h0, 1, 0);
    chk("fl_no_issue", 8'(we0), 8'd0);

    // Continuous push and pop across pointer wrap.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick(1, 3'(i), 4'(i + 1), 1, 0);
      chk("wrap_count", 8'(count), 8'd1);
      if (i > 0) chk("wrap_din0", 8'(din0), 8'(i));
    end
    tick(0, 3'd0, 4'h0, 1, 0);
    chk("wrap_last", 8'(din0), 8'd10);

    // Duplicate address handling.
    do_reset();
    tick(1, 3'd2, 4'h1, 0, 0);
    tick(1, 3'd4, 4'h2, 0, 0);
    tick(1, 3'd2, 4'h9, 0, 0);
`ifdef TUPLE_WR_QUEUE_COALESCE_EN
    chk("dup_count", 8'(count), 8'd2);
    tick(0, 3'd0, 4'h0, 1, 0);
    chk("dup_first", 8'(din0), 8'h9);
`else
    chk("dup_count", 8'(count), 8'd3);
    tick(0, 3'd0, 4'h0, 1, 0);
    chk("dup_first", 8'(din0), 8'h1);
`endif
    for (int i = 0; i < 3; i++) tick(0, 3'd0, 4'h0, 1, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 39) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
